// File: rtl/pipeline_ctrl_n_pkg.sv
// Shared types and constants for the pipeline control unit.
package pipeline_ctrl_n_pkg;

  // Flush sequencer states.
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Stall-bit levels and the reset-active level used throughout the core.
  localparam logic STOP       = 1'b1;
  localparam logic NO_STOP    = 1'b0;
  localparam logic RST_ENABLE = 1'b1;

  // Counter width for a count that must reach n-1, never narrower than 1 bit.
  function automatic int clog2_min1(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_n_stall_mask_gen.sv
// Highest-set-bit to thermometer encoder: every position at or below the
// highest requesting stage is held, positions above it keep moving.
module stall_mask_gen
  import pipeline_ctrl_n_pkg::*;
#(
  parameter int NUM_STAGES = 6
) (
  input  logic [NUM_STAGES-1:0] i_stallreq,
  output logic [NUM_STAGES-1:0] o_mask
);

  // Sweep from the top stage down, OR-accumulating requests seen so far.
  always_comb begin
    logic r_acc;
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    o_mask = {NUM_STAGES{NO_STOP}};
    // NOTE: blocking assignments here: r_acc is a combinational temporary
    // whose new value must be visible to the next loop iteration.
    r_acc  = 1'b0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      r_acc     = r_acc | i_stallreq[k];
      o_mask[k] = r_acc ? STOP : NO_STOP;
    end
  end

endmodule

// File: rtl/pipeline_ctrl_n.sv
// Pipeline control unit: per-stage stall masks, exception/ERET flush
// sequencing with a latched redirect PC, a sticky consecutive-stall watchdog
// and a free-running total stall-cycle counter.
module pipeline_ctrl_n
  import pipeline_ctrl_n_pkg::*;
#(
  parameter int NUM_STAGES   = 6,
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int STALL_LIMIT  = 1024,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] i_stallreq,
  input  logic                  i_except_valid,
  input  logic                  i_except_eret,
  input  logic [ADDR_W-1:0]     i_except_vector,
  input  logic [ADDR_W-1:0]     i_epc,
  output logic [NUM_STAGES-1:0] o_stall,
  output logic                  o_flush,
  output logic [ADDR_W-1:0]     o_new_pc,
  output logic                  o_stall_timeout,
  output logic [CNT_W-1:0]      o_stall_cycles
);

  localparam int HOLD_W = clog2_min1(FLUSH_CYCLES);
  localparam int RUN_W  = $clog2(STALL_LIMIT + 1);

  // Hold count loaded on entry to FLUSH; the RUN cycle that saw the event
  // already provides one flush cycle.
  localparam logic [HOLD_W-1:0] HOLD_INIT =
    (FLUSH_CYCLES > 1) ? HOLD_W'(FLUSH_CYCLES - 2) : '0;
  localparam logic [RUN_W-1:0]  RUN_LIMIT    = RUN_W'(STALL_LIMIT);
  localparam logic [RUN_W-1:0]  RUN_LIMIT_M1 = RUN_W'(STALL_LIMIT - 1);

  state_t              r_state;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [ADDR_W-1:0]   r_pc_latch;
  logic [RUN_W-1:0]    r_run_cnt;
  logic                r_timeout;
  logic [CNT_W-1:0]    r_stall_cycles;

  logic [NUM_STAGES-1:0] w_mask;
  logic [ADDR_W-1:0]     w_target;
  logic                  w_rst_on;
  logic                  w_flush;
  logic                  w_stalled;

  stall_mask_gen #(
    .NUM_STAGES (NUM_STAGES)
  ) u_mask (
    .i_stallreq (i_stallreq),
    .o_mask     (w_mask)
  );

  assign w_rst_on = (rst == RST_ENABLE);
  assign w_target = i_except_eret ? i_epc : i_except_vector;

  // Flush, redirect and stall outputs; an asserted rst forces them low at once.
  always_comb begin
    w_flush  = 1'b0;
    o_new_pc = '0;
    if (!w_rst_on) begin
      if (r_state == FLUSH) begin
        w_flush  = 1'b1;
        o_new_pc = r_pc_latch;
      end else if (i_except_valid) begin
        w_flush  = 1'b1;
        o_new_pc = w_target;
      end
    end
  end

  assign o_flush   = w_flush;
  assign o_stall   = (w_rst_on || w_flush) ? {NUM_STAGES{NO_STOP}} : w_mask;
  assign w_stalled = |o_stall;

  // Flush sequencer: latch the redirect target and count out the hold.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: control registers are reset; the latched PC is reset too so
    // new_pc is deterministic even though it is only used while flushing.
    if (rst == RST_ENABLE) begin
      r_state    <= RUN;
      r_hold_cnt <= '0;
      r_pc_latch <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (i_except_valid && (FLUSH_CYCLES > 1)) begin
            r_pc_latch <= w_target;
            r_hold_cnt <= HOLD_INIT;
            r_state    <= FLUSH;
          end
        end
        FLUSH: begin
          if (r_hold_cnt == '0) begin
            r_state <= RUN;
          end else begin
            r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  // Watchdog: saturating run of consecutive stalled cycles and sticky flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      r_run_cnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (!w_stalled) begin
        r_run_cnt <= '0;
      end else if (r_run_cnt != RUN_LIMIT) begin
        r_run_cnt <= r_run_cnt + RUN_W'(1);
      end
      if (w_stalled && (r_run_cnt == RUN_LIMIT_M1)) begin
        r_timeout <= 1'b1;
      end
    end
  end

  // Total stalled-cycle counter, wrapping at its width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      r_stall_cycles <= '0;
    end else if (w_stalled) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign o_stall_timeout = r_timeout;
  assign o_stall_cycles  = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_ctrl_n.sv
// Directed bench for pipeline_ctrl_n: stall masks, flush sequencing,
// watchdog, counter wrap and asynchronous reset in mid-flush.
module tb_pipeline_ctrl_n;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stallreq;
  logic        except_valid;
  logic        except_eret;
  logic [31:0] except_vector;
  logic [31:0] epc;

  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
  logic [3:0]  stall_cycles;

  logic [5:0]  d1_stall;
  logic        d1_flush;
  logic [31:0] d1_new_pc;
  logic        d1_timeout;
  logic [31:0] d1_cycles;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_ctrl_n #(
    .NUM_STAGES   (6),
    .ADDR_W       (32),
    .FLUSH_CYCLES (3),
    .STALL_LIMIT  (4),
    .CNT_W        (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_stallreq      (stallreq),
    .i_except_valid  (except_valid),
    .i_except_eret   (except_eret),
    .i_except_vector (except_vector),
    .i_epc           (epc),
    .o_stall         (stall),
    .o_flush         (flush),
    .o_new_pc        (new_pc),
    .o_stall_timeout (stall_timeout),
    .o_stall_cycles  (stall_cycles)
  );

  // Single-cycle flush variant sharing the same stimulus.
  pipeline_ctrl_n #(
    .NUM_STAGES   (6),
    .ADDR_W       (32),
    .FLUSH_CYCLES (1)
  ) dut1 (
    .clk             (clk),
    .rst             (rst),
    .i_stallreq      (stallreq),
    .i_except_valid  (except_valid),
    .i_except_eret   (except_eret),
    .i_except_vector (except_vector),
    .i_epc           (epc),
    .o_stall         (d1_stall),
    .o_flush         (d1_flush),
    .o_new_pc        (d1_new_pc),
    .o_stall_timeout (d1_timeout),
    .o_stall_cycles  (d1_cycles)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] req_tab [5] = '{6'b000100, 6'b001000, 6'b001100, 6'b100000, 6'b000000};
  logic [5:0] exp_tab [5] = '{6'b000111, 6'b001111, 6'b001111, 6'b111111, 6'b000000};

  initial begin
    rst = 1'b1; stallreq = '0; except_valid = 1'b0; except_eret = 1'b0;
    except_vector = '0; epc = '0;
    #2;
    check("rst_stall",   stall, 0);
    check("rst_flush",   flush, 0);
    check("rst_new_pc",  new_pc, 0);
    check("rst_timeout", stall_timeout, 0);
    check("rst_cycles",  stall_cycles, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Combinational stall masks, applied within one cycle.
    for (int i = 0; i < 5; i++) begin
      stallreq = req_tab[i];
      #1;
      check($sformatf("mask_%0d", i), stall, exp_tab[i]);
    end
    check("cycles_idle", stall_cycles, 0);

    // Exception, 3-cycle flush; later exceptions during FLUSH are ignored.
    step();
    except_valid = 1'b1; except_eret = 1'b0; except_vector = 32'h20; #1;
    check("exc_t_flush", flush, 1);
    check("exc_t_pc",    new_pc, 32'h20);
    check("d1_t_flush",  d1_flush, 1);
    check("d1_t_pc",     d1_new_pc, 32'h20);
    step(); except_vector = 32'h40; #1;
    check("exc_t1_flush", flush, 1);
    check("exc_t1_pc",    new_pc, 32'h20);
    check("d1_t1_pc",     d1_new_pc, 32'h40);
    step(); except_vector = 32'h60; #1;
    check("exc_t2_flush", flush, 1);
    check("exc_t2_pc",    new_pc, 32'h20);
    // First RUN cycle after the flush: a new exception starts a new flush.
    step(); except_vector = 32'h80; #1;
    check("exc_t3_flush", flush, 1);
    check("exc_t3_pc",    new_pc, 32'h80);
    step(); except_valid = 1'b0; #1;
    check("exc_t4_flush", flush, 1);
    check("exc_t4_pc",    new_pc, 32'h80);
    step();
    check("exc_t5_flush", flush, 1);
    step();
    check("exc_t6_flush", flush, 0);
    check("exc_t6_pc",    new_pc, 0);
    check("d1_t6_flush",  d1_flush, 0);

    // ERET together with a stall request: flush wins, no counting.
    stallreq = 6'b001000; except_valid = 1'b1; except_eret = 1'b1;
    epc = 32'h1234; except_vector = 32'h20; #1;
    check("eret_flush", flush, 1);
    check("eret_pc",    new_pc, 32'h1234);
    check("eret_stall", stall, 0);
    step(); except_valid = 1'b0; except_eret = 1'b0; #1;
    check("eret_hold_stall", stall, 0);
    check("eret_hold_pc",    new_pc, 32'h1234);
    stallreq = '0;
    step(); step();
    check("eret_end_flush", flush, 0);
    check("eret_cycles",    stall_cycles, 0);

    // Watchdog reaches its limit after 4 consecutive stalled cycles.
    stallreq = 6'b000100;
    repeat (3) step();
    check("wd_3_timeout", stall_timeout, 0);
    check("wd_3_cycles",  stall_cycles, 3);
    step();
    check("wd_4_timeout", stall_timeout, 1);
    stallreq = '0;
    step();
    check("wd_sticky",    stall_timeout, 1);
    check("wd_cycles",    stall_cycles, 4);

    // Interrupted runs never reach the limit.
    rst = 1'b1; #1;
    check("rst2_timeout", stall_timeout, 0);
    check("rst2_cycles",  stall_cycles, 0);
    rst = 1'b0;
    step();
    stallreq = 6'b000100; repeat (3) step();
    stallreq = '0;        step();
    stallreq = 6'b000100; repeat (3) step();
    stallreq = '0; #1;
    check("gap_timeout", stall_timeout, 0);
    check("gap_cycles",  stall_cycles, 6);

    // 4-bit counter wraps after 16.
    rst = 1'b1; #1; rst = 1'b0;
    step();
    stallreq = 6'b100000; repeat (17) step();
    stallreq = '0; #1;
    check("wrap_cycles",  stall_cycles, 1);
    check("wrap_timeout", stall_timeout, 1);

    // Asynchronous reset in the second FLUSH cycle.
    except_valid = 1'b1; except_vector = 32'h20;
    step();
    except_valid = 1'b1; stallreq = 6'b001000; #1;
    check("mid_pre_flush", flush, 1);
    #1 rst = 1'b1; #1;
    check("mid_flush",   flush, 0);
    check("mid_pc",      new_pc, 0);
    check("mid_stall",   stall, 0);
    check("mid_timeout", stall_timeout, 0);
    check("mid_cycles",  stall_cycles, 0);
    step();
    rst = 1'b0; except_valid = 1'b0; stallreq = 6'b000100; #1;
    check("post_flush", flush, 0);
    check("post_stall", stall, 6'b000111);
    step();
    check("post_cycles", stall_cycles, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
